// File: rtl/mem_sp_ram_clr_pkg.sv
// ----------------------------------------------------------------------------
// mem_sp_ram_clr_pkg
//   Shared definitions for the single-port RAM with clear engine.
//   Holds the clear-engine FSM state encoding used by the top level.
// ----------------------------------------------------------------------------
package mem_sp_ram_clr_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/mem_sp_ram_clr_array.sv
// ----------------------------------------------------------------------------
// mem_sp_array
//   Plain WIDTH x DEPTH synchronous storage array: one write port and one
//   registered read port. It has no reset, so it maps onto block RAM.
//   Callers guarantee that addresses are < DEPTH whenever an enable is high.
// Ports
//   clk      in   rising-edge clock
//   wr_en    in   write strobe
//   wr_addr  in   AW-bit write address
//   wr_data  in   WIDTH-bit write data
//   rd_en    in   read strobe; rd_data updates only when set, otherwise holds
//   rd_addr  in   AW-bit read address
//   rd_data  out  WIDTH-bit registered read data
// ----------------------------------------------------------------------------
module mem_sp_array #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/mem_sp_ram_clr.sv
// ----------------------------------------------------------------------------
// mem_sp_ram_clr
//   Parametrised single-port synchronous RAM with access/write enables, a
//   read-valid strobe, an optional output register and a clear engine that
//   sweeps every word to CLR_VALUE after reset (optional) or on a clr pulse.
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   en        in   access request, accepted only when ready=1
//   we        in   1 = write, 0 = read
//   address   in   AW-bit word address
//   datain    in   WIDTH-bit write data
//   clr       in   one-cycle pulse, starts or restarts the clear sweep
//   dataout   out  WIDTH-bit read data (holds between reads)
//   dvalid    out  one-cycle pulse, dataout carries requested read data
//   ready     out  accepting accesses (= ~busy)
//   busy      out  clear sweep in progress
//   addr_err  out  one-cycle pulse, accepted access had address >= DEPTH
// ----------------------------------------------------------------------------
module mem_sp_ram_clr
   import mem_sp_ram_clr_pkg::*;
#(
   parameter int               WIDTH        = 8,
   parameter int               DEPTH        = 1024,
   parameter int               AW           = 10,
   parameter int               OUT_REG      = 0,
   parameter int               CLR_ON_RESET = 1,
   parameter logic [WIDTH-1:0] CLR_VALUE    = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             we,
   input  logic [AW-1:0]    address,
   input  logic [WIDTH-1:0] datain,
   input  logic             clr,
   output logic [WIDTH-1:0] dataout,
   output logic             dvalid,
   output logic             ready,
   output logic             busy,
   output logic             addr_err
);

   // One extra bit so DEPTH = 2**AW still compares correctly.
   localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH-1);
   localparam state_t        ST_RST  = (CLR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

   state_t           state_reg, state_next;
   logic [AW-1:0]    cnt_reg, cnt_next;

   logic             in_range;
   logic             accept, rd_acc, wr_acc;
   logic             arr_we, arr_re;
   logic [AW-1:0]    arr_waddr;
   logic [WIDTH-1:0] arr_wdata, arr_rdata;

   logic             dv1_reg, rerr1_reg, werr_reg, zero1_reg;
   logic [WIDTH-1:0] dout1;
   logic             rd_err;

   assign busy     = (state_reg == ST_CLEAR);
   assign ready    = ~busy;
   assign in_range = ({1'b0, address} < DEPTH_L);
   // clr wins over a same-cycle access: the access is simply dropped.
   assign accept   = en & ready & ~clr;
   assign rd_acc   = accept & ~we;
   assign wr_acc   = accept & we;

   // ---------------- clear engine ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_RST;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (clr) begin
               state_next = ST_CLEAR;
               cnt_next   = '0;
            end
         end
         ST_CLEAR: begin
            if (clr) begin
               cnt_next = '0;
            end else if (cnt_reg == LAST) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + AW'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // ---------------- storage ----------------
   // The sweep owns the write port while busy; user accesses cannot be
   // accepted then, so no arbitration is needed.
   assign arr_we    = busy | (wr_acc & in_range);
   assign arr_waddr = busy ? cnt_reg : address;
   assign arr_wdata = busy ? CLR_VALUE : datain;
   assign arr_re    = rd_acc & in_range;

   mem_sp_array #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .wr_en   (arr_we),
      .wr_addr (arr_waddr),
      .wr_data (arr_wdata),
      .rd_en   (arr_re),
      .rd_addr (address),
      .rd_data (arr_rdata)
   );

   // ---------------- read stage 1 ----------------
   // zero1_reg forces the first stage to 0 after reset and after an
   // out-of-range read; the array register itself carries no reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dv1_reg   <= 1'b0;
         rerr1_reg <= 1'b0;
         werr_reg  <= 1'b0;
         zero1_reg <= 1'b1;
      end else begin
         dv1_reg   <= rd_acc;
         rerr1_reg <= rd_acc & ~in_range;
         werr_reg  <= wr_acc & ~in_range;
         if (rd_acc) begin
            zero1_reg <= ~in_range;
         end
      end
   end

   assign dout1 = zero1_reg ? '0 : arr_rdata;

   // ---------------- optional output register ----------------
   generate
      if (OUT_REG != 0) begin : g_oreg
         logic             dv2_reg, rerr2_reg;
         logic [WIDTH-1:0] dout2_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               dv2_reg   <= 1'b0;
               rerr2_reg <= 1'b0;
               dout2_reg <= '0;
            end else begin
               dv2_reg   <= dv1_reg;
               rerr2_reg <= rerr1_reg;
               if (dv1_reg) begin
                  dout2_reg <= dout1;
               end
            end
         end

         assign dataout = dout2_reg;
         assign dvalid  = dv2_reg;
         assign rd_err  = rerr2_reg;
      end else begin : g_noreg
         assign dataout = dout1;
         assign dvalid  = dv1_reg;
         assign rd_err  = rerr1_reg;
      end
   endgenerate

   // Read errors ride with dvalid; write errors appear one cycle after accept.
   assign addr_err = rd_err | werr_reg;

endmodule

// File: tb/tb_mem_sp_ram_clr.sv
// ----------------------------------------------------------------------------
// tb_mem_sp_ram_clr
//   Directed bench for mem_sp_ram_clr. Three instances:
//     a: defaults (1024 x 8, latency 1)
//     b: DEPTH=1000 for out-of-range checks
//     c: OUT_REG=1 (latency 2) and reset-mid-read
// ----------------------------------------------------------------------------
module tb_mem_sp_ram_clr;

   logic       clk;
   logic       we;
   logic [9:0] address;
   logic [7:0] datain;

   logic       rst_a, en_a, clr_a, dvalid_a, ready_a, busy_a, addr_err_a;
   logic [7:0] dataout_a;
   logic       rst_b, en_b, clr_b, dvalid_b, ready_b, busy_b, addr_err_b;
   logic [7:0] dataout_b;
   logic       rst_c, en_c, clr_c, dvalid_c, ready_c, busy_c, addr_err_c;
   logic [7:0] dataout_c;

   int n_cmp;
   int n_bad;

   mem_sp_ram_clr u_a (
      .clk(clk), .rst(rst_a), .en(en_a), .we(we), .address(address),
      .datain(datain), .clr(clr_a), .dataout(dataout_a), .dvalid(dvalid_a),
      .ready(ready_a), .busy(busy_a), .addr_err(addr_err_a)
   );

   mem_sp_ram_clr #(.DEPTH(1000), .AW(10)) u_b (
      .clk(clk), .rst(rst_b), .en(en_b), .we(we), .address(address),
      .datain(datain), .clr(clr_b), .dataout(dataout_b), .dvalid(dvalid_b),
      .ready(ready_b), .busy(busy_b), .addr_err(addr_err_b)
   );

   mem_sp_ram_clr #(.OUT_REG(1)) u_c (
      .clk(clk), .rst(rst_c), .en(en_c), .we(we), .address(address),
      .datain(datain), .clr(clr_c), .dataout(dataout_c), .dvalid(dvalid_c),
      .ready(ready_c), .busy(busy_c), .addr_err(addr_err_c)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog: stop a hung run with a visible failure.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------
   task automatic test_reset();
      tick();
      tick();
      n_cmp++;
      if (busy_a !== 1'b1 || ready_a !== 1'b0 || dvalid_a !== 1'b0 ||
          dataout_a !== 8'd0 || addr_err_a !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: busy=%b ready=%b dvalid=%b dataout=%0d addr_err=%b, required 1 0 0 0 0",
                  busy_a, ready_a, dvalid_a, dataout_a, addr_err_a);
      end
      $display("reset  a busy=%b ready=%b dataout=%0d", busy_a, ready_a, dataout_a);
   endtask

   task automatic test_reset_sweep();
      int n;
      rst_a = 1'b1;
      n = 0;
      while (busy_a === 1'b1 && n < 3000) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n != 1024 || ready_a !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_sweep_len: busy cycles=%0d ready=%b, required 1024 and ready=1", n, ready_a);
      end
      $display("sweep  a busy cycles=%0d", n);
      // read a freshly cleared word
      en_a = 1'b1; we = 1'b0; address = 10'd800;
      n_cmp++;
      if (dvalid_a !== 1'b0) begin
         n_bad++;
         $display("FAIL rd_early: dvalid=%b before accept, required 0", dvalid_a);
      end
      tick();
      en_a = 1'b0;
      n_cmp++;
      if (dvalid_a !== 1'b1 || dataout_a !== 8'd0 || addr_err_a !== 1'b0) begin
         n_bad++;
         $display("FAIL rd_cleared: dvalid=%b dataout=%0d addr_err=%b, required 1 0 0",
                  dvalid_a, dataout_a, addr_err_a);
      end
      $display("read   a addr=800 data=%0d dvalid=%b", dataout_a, dvalid_a);
      tick();
      n_cmp++;
      if (dvalid_a !== 1'b0) begin
         n_bad++;
         $display("FAIL dvalid_pulse: dvalid=%b, required 0", dvalid_a);
      end
   endtask

   task automatic test_back_to_back();
      en_a = 1'b1; we = 1'b1; address = 10'd800; datain = 8'd50;
      tick();
      $display("write  a addr=800 data=50");
      address = 10'd900; datain = 8'd60;
      tick();
      $display("write  a addr=900 data=60");
      n_cmp++;
      if (dvalid_a !== 1'b0 || addr_err_a !== 1'b0) begin
         n_bad++;
         $display("FAIL wr_no_dvalid: dvalid=%b addr_err=%b, required 0 0", dvalid_a, addr_err_a);
      end
      we = 1'b0; address = 10'd800;
      tick();
      n_cmp++;
      if (dvalid_a !== 1'b1 || dataout_a !== 8'd50) begin
         n_bad++;
         $display("FAIL b2b_rd0: dvalid=%b dataout=%0d, required 1 50", dvalid_a, dataout_a);
      end
      $display("read   a addr=800 data=%0d dvalid=%b", dataout_a, dvalid_a);
      address = 10'd900;
      tick();
      en_a = 1'b0;
      n_cmp++;
      if (dvalid_a !== 1'b1 || dataout_a !== 8'd60) begin
         n_bad++;
         $display("FAIL b2b_rd1: dvalid=%b dataout=%0d, required 1 60", dvalid_a, dataout_a);
      end
      $display("read   a addr=900 data=%0d dvalid=%b", dataout_a, dvalid_a);
      tick();
      n_cmp++;
      if (dvalid_a !== 1'b0 || dataout_a !== 8'd60) begin
         n_bad++;
         $display("FAIL hold: dvalid=%b dataout=%0d, required 0 60", dvalid_a, dataout_a);
      end
   endtask

   task automatic test_clear_ignore();
      int n;
      int bad_flags;
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      n_cmp++;
      if (busy_a !== 1'b1 || ready_a !== 1'b0) begin
         n_bad++;
         $display("FAIL clr_start: busy=%b ready=%b, required 1 0", busy_a, ready_a);
      end
      en_a = 1'b1; we = 1'b1; address = 10'd800; datain = 8'd99;
      n = 0;
      bad_flags = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n++;
         if (dvalid_a !== 1'b0 || addr_err_a !== 1'b0) bad_flags++;
      end
      en_a = 1'b0;
      $display("write  a addr=800 data=99 while busy (ignored)");
      n_cmp++;
      if (bad_flags != 0) begin
         n_bad++;
         $display("FAIL busy_flags: %0d cycles with flags set, required 0", bad_flags);
      end
      while (busy_a === 1'b1 && n < 3000) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n != 1024) begin
         n_bad++;
         $display("FAIL clr_sweep_len: busy cycles=%0d, required 1024", n);
      end
      we = 1'b0; en_a = 1'b1; address = 10'd800;
      tick();
      en_a = 1'b0;
      n_cmp++;
      if (dvalid_a !== 1'b1 || dataout_a !== 8'd0) begin
         n_bad++;
         $display("FAIL clr_content: dvalid=%b dataout=%0d, required 1 0", dvalid_a, dataout_a);
      end
      $display("read   a addr=800 data=%0d dvalid=%b", dataout_a, dvalid_a);
   endtask

   task automatic test_clear_restart();
      int n;
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      for (int i = 0; i < 499; i++) tick();
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      n = 0;
      while (busy_a === 1'b1 && n < 3000) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n != 1024) begin
         n_bad++;
         $display("FAIL clr_restart_len: busy cycles after 2nd pulse=%0d, required 1024", n);
      end
      $display("clear  a restart busy cycles=%0d", n);
   endtask

   task automatic test_addr_err();
      int n;
      rst_b = 1'b1;
      n = 0;
      while (busy_b === 1'b1 && n < 3000) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n != 1000) begin
         n_bad++;
         $display("FAIL b_sweep_len: busy cycles=%0d, required 1000", n);
      end
      en_b = 1'b1; we = 1'b1; address = 10'd999; datain = 8'd5;
      tick();
      $display("write  b addr=999 data=5");
      we = 1'b0;
      tick();
      n_cmp++;
      if (dvalid_b !== 1'b1 || dataout_b !== 8'd5 || addr_err_b !== 1'b0) begin
         n_bad++;
         $display("FAIL b_last_word: dvalid=%b dataout=%0d addr_err=%b, required 1 5 0",
                  dvalid_b, dataout_b, addr_err_b);
      end
      $display("read   b addr=999 data=%0d dvalid=%b", dataout_b, dvalid_b);
      we = 1'b1; address = 10'd1010; datain = 8'd7;
      tick();
      en_b = 1'b0;
      n_cmp++;
      if (addr_err_b !== 1'b1 || dvalid_b !== 1'b0) begin
         n_bad++;
         $display("FAIL wr_addr_err: addr_err=%b dvalid=%b, required 1 0", addr_err_b, dvalid_b);
      end
      $display("write  b addr=1010 data=7 addr_err=%b", addr_err_b);
      tick();
      n_cmp++;
      if (addr_err_b !== 1'b0) begin
         n_bad++;
         $display("FAIL wr_err_pulse: addr_err=%b, required 0", addr_err_b);
      end
      en_b = 1'b1; we = 1'b0;
      tick();
      en_b = 1'b0;
      n_cmp++;
      if (dvalid_b !== 1'b1 || dataout_b !== 8'd0 || addr_err_b !== 1'b1) begin
         n_bad++;
         $display("FAIL rd_addr_err: dvalid=%b dataout=%0d addr_err=%b, required 1 0 1",
                  dvalid_b, dataout_b, addr_err_b);
      end
      $display("read   b addr=1010 data=%0d dvalid=%b addr_err=%b", dataout_b, dvalid_b, addr_err_b);
      tick();
      n_cmp++;
      if (dvalid_b !== 1'b0 || addr_err_b !== 1'b0) begin
         n_bad++;
         $display("FAIL rd_err_pulse: dvalid=%b addr_err=%b, required 0 0", dvalid_b, addr_err_b);
      end
   endtask

   task automatic test_out_reg();
      int n;
      rst_c = 1'b1;
      n = 0;
      while (busy_c === 1'b1 && n < 3000) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n != 1024) begin
         n_bad++;
         $display("FAIL c_sweep_len: busy cycles=%0d, required 1024", n);
      end
      en_c = 1'b1; we = 1'b1; address = 10'd900; datain = 8'd33;
      tick();
      $display("write  c addr=900 data=33");
      we = 1'b0;
      tick();
      en_c = 1'b0;
      n_cmp++;
      if (dvalid_c !== 1'b0) begin
         n_bad++;
         $display("FAIL oreg_lat1: dvalid=%b one cycle after accept, required 0", dvalid_c);
      end
      tick();
      n_cmp++;
      if (dvalid_c !== 1'b1 || dataout_c !== 8'd33) begin
         n_bad++;
         $display("FAIL oreg_lat2: dvalid=%b dataout=%0d, required 1 33", dvalid_c, dataout_c);
      end
      $display("read   c addr=900 data=%0d dvalid=%b", dataout_c, dvalid_c);
      tick();
      n_cmp++;
      if (dvalid_c !== 1'b0 || dataout_c !== 8'd33) begin
         n_bad++;
         $display("FAIL oreg_hold: dvalid=%b dataout=%0d, required 0 33", dvalid_c, dataout_c);
      end
      // accept a read, then reset while it is in flight
      en_c = 1'b1;
      tick();
      en_c = 1'b0;
      rst_c = 1'b0;
      #1;
      n_cmp++;
      if (dvalid_c !== 1'b0 || dataout_c !== 8'd0 || addr_err_c !== 1'b0 || busy_c !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid_read: dvalid=%b dataout=%0d addr_err=%b busy=%b, required 0 0 0 1",
                  dvalid_c, dataout_c, addr_err_c, busy_c);
      end
      tick();
      tick();
      n_cmp++;
      if (dvalid_c !== 1'b0 || dataout_c !== 8'd0) begin
         n_bad++;
         $display("FAIL rst_read_lost: dvalid=%b dataout=%0d, required 0 0", dvalid_c, dataout_c);
      end
      $display("reset  c mid-read dvalid=%b data=%0d", dvalid_c, dataout_c);
      rst_c = 1'b1;
      n = 0;
      while (busy_c === 1'b1 && n < 3000) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n != 1024) begin
         n_bad++;
         $display("FAIL c_resweep_len: busy cycles=%0d, required 1024", n);
      end
   endtask

   // ---------------------------------------------------------------
   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      we      = 1'b0;
      address = '0;
      datain  = '0;
      rst_a = 1'b0; en_a = 1'b0; clr_a = 1'b0;
      rst_b = 1'b0; en_b = 1'b0; clr_b = 1'b0;
      rst_c = 1'b0; en_c = 1'b0; clr_c = 1'b0;

      test_reset();
      test_reset_sweep();
      test_back_to_back();
      test_clear_ignore();
      test_clear_restart();
      test_addr_err();
      test_out_reg();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
